handwash_poll_sequencer: RTL and testbench

Sequencer that drives the shared ranging sensor bus and feeds the handwash sensor datapath. It polls the left-hand channel, then the right-hand channel, once per poll period over a single req/valid sensor port. Each result is delivered as a one-cycle accept strobe with data. It also owns the per-hand gain registers: defaults are loaded after reset, and a configuration write port allows runtime updates. It sits in the 10 MHz sensor clock domain, between the sensor front-end and the handwash sensor block.

---
 rtl/handwash_pkg.sv | 18 +
 rtl/poll_down_counter.sv | 27 ++
 rtl/handwash_poll_sequencer.sv | 134 +++++++++++++
 tb/tb_handwash_poll_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handwash_pkg.sv
// rtl/handwash_pkg.sv - shared types and widths for the handwash poll sequencer
package handwash_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    REQ_L = 2'd1,
    REQ_R = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam int DIST_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 7;

  // 1.0 in Q1.7
  localparam logic [GAIN_W-1:0] DEFAULT_GAIN = 8'd128;

endpackage

// File: rtl/poll_down_counter.sv
// rtl/poll_down_counter.sv - loadable down counter that saturates at zero
module poll_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/handwash_poll_sequencer.sv
// rtl/handwash_poll_sequencer.sv - polls left then right ranging channel each period and owns the per-hand gains
module handwash_poll_sequencer
  import handwash_pkg::*;
#(
  parameter int unsigned       POLL_INTERVAL   = 100000,
  parameter int unsigned       TIMEOUT         = 5000,
  parameter logic [GAIN_W-1:0] LEFT_GAIN_INIT  = DEFAULT_GAIN,
  parameter logic [GAIN_W-1:0] RIGHT_GAIN_INIT = DEFAULT_GAIN
) (
  input  logic              clk,
  input  logic              reset,
  output logic              sensorReq,
  output logic              sensorSel,
  input  logic              sensorValid,
  input  logic [DIST_W-1:0] sensorData,
  input  logic              cfgWrite,
  input  logic              cfgSel,
  input  logic [GAIN_W-1:0] cfgGain,
  output logic              acceptLeftHandDistance,
  output logic [DIST_W-1:0] leftHandDistance,
  output logic              acceptLeftHandGain,
  output logic [GAIN_W-1:0] leftHandGain,
  output logic              acceptRightHandDistance,
  output logic [DIST_W-1:0] rightHandDistance,
  output logic              acceptRightHandGain,
  output logic [GAIN_W-1:0] rightHandGain,
  output logic              leftFault,
  output logic              rightFault
);

  localparam int IW = $clog2(POLL_INTERVAL);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t state;
  logic   in_req_state, arming, got_valid, tmo_zero, ivl_zero, ivl_load;

  // A REQ state with sensorReq low is its arming cycle; this also gives the gap between sides.
  assign in_req_state = (state == REQ_L) || (state == REQ_R);
  assign arming       = in_req_state && !sensorReq;
  assign got_valid    = sensorReq && sensorValid;
  assign ivl_load     = (state == REQ_R) && sensorReq && (sensorValid || tmo_zero);

  poll_down_counter #(.W(TW)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (arming),
    .value (TW'(TIMEOUT - 1)),
    .dec   (sensorReq),
    .zero  (tmo_zero)
  );

  poll_down_counter #(.W(IW)) u_interval (
    .clk   (clk),
    .reset (reset),
    .load  (ivl_load),
    .value (IW'(POLL_INTERVAL - 1)),
    .dec   (state == IDLE),
    .zero  (ivl_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= INIT;
      sensorReq               <= 1'b0;
      sensorSel               <= 1'b0;
      acceptLeftHandDistance  <= 1'b0;
      acceptRightHandDistance <= 1'b0;
      acceptLeftHandGain      <= 1'b0;
      acceptRightHandGain     <= 1'b0;
      leftHandDistance        <= '0;
      rightHandDistance       <= '0;
      leftHandGain            <= '0;
      rightHandGain           <= '0;
      leftFault               <= 1'b0;
      rightFault              <= 1'b0;
    end else begin
      acceptLeftHandDistance  <= 1'b0;
      acceptRightHandDistance <= 1'b0;
      acceptLeftHandGain      <= 1'b0;
      acceptRightHandGain     <= 1'b0;

      case (state)
        INIT: begin
          leftHandGain        <= LEFT_GAIN_INIT;
          rightHandGain       <= RIGHT_GAIN_INIT;
          acceptLeftHandGain  <= 1'b1;
          acceptRightHandGain <= 1'b1;
          state               <= REQ_L;
        end
        REQ_L: begin
          if (arming) begin
            sensorReq <= 1'b1;
            sensorSel <= 1'b0;
          end else if (got_valid || tmo_zero) begin
            // A timed-out read reports distance 0 so downstream shuts the water off.
            leftHandDistance       <= got_valid ? sensorData : '0;
            leftFault              <= !got_valid;
            acceptLeftHandDistance <= 1'b1;
            sensorReq              <= 1'b0;
            state                  <= REQ_R;
          end
        end
        REQ_R: begin
          if (arming) begin
            sensorReq <= 1'b1;
            sensorSel <= 1'b1;
          end else if (got_valid || tmo_zero) begin
            rightHandDistance       <= got_valid ? sensorData : '0;
            rightFault              <= !got_valid;
            acceptRightHandDistance <= 1'b1;
            sensorReq               <= 1'b0;
            state                   <= IDLE;
          end
        end
        IDLE: begin
          if (ivl_zero) state <= REQ_L;
        end
        default: state <= INIT;
      endcase

      // Runtime writes take precedence over the INIT defaults for the written side.
      if (cfgWrite) begin
        if (cfgSel) begin
          rightHandGain       <= cfgGain;
          acceptRightHandGain <= 1'b1;
        end else begin
          leftHandGain       <= cfgGain;
          acceptLeftHandGain <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_handwash_poll_sequencer.sv
// tb/tb_handwash_poll_sequencer.sv - scoreboard bench for the handwash poll sequencer
module tb_handwash_poll_sequencer;
  import handwash_pkg::*;

  localparam int POLL = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sensorReq, sensorSel;
  logic        sensorValid = 1'b0;
  logic [15:0] sensorData = '0;
  logic        cfgWrite = 1'b0;
  logic        cfgSel = 1'b0;
  logic [7:0]  cfgGain = '0;
  logic        acceptLeftHandDistance, acceptLeftHandGain;
  logic        acceptRightHandDistance, acceptRightHandGain;
  logic [15:0] leftHandDistance, rightHandDistance;
  logic [7:0]  leftHandGain, rightHandGain;
  logic        leftFault, rightFault;

  handwash_poll_sequencer #(
    .POLL_INTERVAL  (POLL),
    .TIMEOUT        (TMO),
    .LEFT_GAIN_INIT (8'd128),
    .RIGHT_GAIN_INIT(8'd128)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .sensorReq              (sensorReq),
    .sensorSel              (sensorSel),
    .sensorValid            (sensorValid),
    .sensorData             (sensorData),
    .cfgWrite               (cfgWrite),
    .cfgSel                 (cfgSel),
    .cfgGain                (cfgGain),
    .acceptLeftHandDistance (acceptLeftHandDistance),
    .leftHandDistance       (leftHandDistance),
    .acceptLeftHandGain     (acceptLeftHandGain),
    .leftHandGain           (leftHandGain),
    .acceptRightHandDistance(acceptRightHandDistance),
    .rightHandDistance      (rightHandDistance),
    .acceptRightHandGain    (acceptRightHandGain),
    .rightHandGain          (rightHandGain),
    .leftFault              (leftFault),
    .rightFault             (rightFault)
  );

  always #5 clk = ~clk;

  // Kinds: 0 left distance, 1 left gain, 2 right distance, 3 right gain.
  typedef struct {
    logic [15:0] val;
    int          cyc;
  } ev_t;

  ev_t exp_q[4][$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      0: return "left_distance";
      1: return "left_gain";
      2: return "right_distance";
      default: return "right_gain";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [3:0]  stb;
    logic [15:0] val [4];
    ev_t         e;
    stb = {acceptRightHandGain, acceptRightHandDistance, acceptLeftHandGain, acceptLeftHandDistance};
    val[0] = leftHandDistance;
    val[1] = {8'd0, leftHandGain};
    val[2] = rightHandDistance;
    val[3] = {8'd0, rightHandGain};
    for (int k = 0; k < 4; k++) begin
      if (stb[k] === 1'b1) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL %s_strobe: unexpected strobe at cycle %0d value %0d, required none", kind_name(k), cyc, val[k]);
        end else begin
          e = exp_q[k].pop_front();
          if (val[k] !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_strobe: got value %0d at cycle %0d, required %0d at cycle %0d", kind_name(k), val[k], cyc, e.val, e.cyc);
          end
        end
      end
    end
  end

  task automatic push_ev(input int k, input logic [15:0] v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    exp_q[k].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int rc);
    int n = 0;
    while (sensorReq !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (sensorReq !== 1'b1) begin
      errors++;
      $display("FAIL req_wait: sensorReq still %b after %0d cycles, required 1", sensorReq, n);
    end
    rc = cyc;
  endtask

  task automatic serve(input bit side, input int lat, input logic [15:0] data, output int rc);
    wait_req(rc);
    checks++;
    if (sensorSel !== side) begin
      errors++;
      $display("FAIL serve_sel: sensorSel %b, required %b", sensorSel, side);
    end
    if (lat > 1) tick(lat - 1);
    sensorValid = 1'b1;
    sensorData  = data;
    push_ev(side ? 2 : 0, data, cyc + 1);
    tick(1);
    sensorValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({sensorReq, sensorSel, leftFault, rightFault} !== 4'b0 ||
        {acceptLeftHandDistance, acceptLeftHandGain, acceptRightHandDistance, acceptRightHandGain} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/sel/faults=%b strobes=%b, required all 0",
               {sensorReq, sensorSel, leftFault, rightFault},
               {acceptLeftHandDistance, acceptLeftHandGain, acceptRightHandDistance, acceptRightHandGain});
    end
    checks++;
    if (leftHandDistance !== 16'd0 || rightHandDistance !== 16'd0 || leftHandGain !== 8'd0 || rightHandGain !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: dist %0d/%0d gain %0d/%0d, required 0/0 0/0",
               leftHandDistance, rightHandDistance, leftHandGain, rightHandGain);
    end
    reset = 1'b0;
    push_ev(1, 16'd128, cyc + 1);
    push_ev(3, 16'd128, cyc + 1);
    tick(1);
    checks++;
    if (leftHandGain !== 8'd128 || rightHandGain !== 8'd128 || sensorReq !== 1'b0) begin
      errors++;
      $display("FAIL init_gains: gains %0d/%0d req %b, required 128/128 req 0", leftHandGain, rightHandGain, sensorReq);
    end
  endtask

  task automatic test_left_valid;
    tick(1);
    checks++;
    if (sensorReq !== 1'b1 || sensorSel !== 1'b0) begin
      errors++;
      $display("FAIL req_l_start: req %b sel %b, required 1 0", sensorReq, sensorSel);
    end
    tick(2);
    sensorValid = 1'b1;
    sensorData  = 16'd1200;
    push_ev(0, 16'd1200, cyc + 1);
    tick(1);
    sensorValid = 1'b0;
    checks++;
    if (sensorReq !== 1'b0 || leftHandDistance !== 16'd1200 || leftFault !== 1'b0) begin
      errors++;
      $display("FAIL left_accept: req %b dist %0d fault %b, required 0 1200 0", sensorReq, leftHandDistance, leftFault);
    end
    tick(1);
    checks++;
    if (sensorReq !== 1'b1 || sensorSel !== 1'b1) begin
      errors++;
      $display("FAIL gap_one_cycle: req %b sel %b, required 1 1", sensorReq, sensorSel);
    end
  endtask

  task automatic test_right_timeout;
    int n = 0;
    int rc;
    push_ev(2, 16'd0, cyc + TMO);
    while (sensorReq === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL timeout_len: sensorReq high %0d cycles, required %0d", n, TMO);
    end
    checks++;
    if (rightFault !== 1'b1 || rightHandDistance !== 16'd0) begin
      errors++;
      $display("FAIL timeout_fault: fault %b dist %0d, required 1 0", rightFault, rightHandDistance);
    end
    serve(1'b0, 1, 16'd500, rc);
    serve(1'b1, 1, 16'd900, rc);
    checks++;
    if (rightFault !== 1'b0 || rightHandDistance !== 16'd900) begin
      errors++;
      $display("FAIL fault_clear: fault %b dist %0d, required 0 900", rightFault, rightHandDistance);
    end
  endtask

  task automatic test_cfg_during_req;
    int rc;
    wait_req(rc);
    cfgWrite = 1'b1;
    cfgSel   = 1'b1;
    cfgGain  = 8'd64;
    push_ev(3, 16'd64, cyc + 1);
    tick(1);
    cfgSel  = 1'b0;
    cfgGain = 8'd10;
    push_ev(1, 16'd10, cyc + 1);
    checks++;
    if (rightHandGain !== 8'd64 || sensorReq !== 1'b1 || sensorSel !== 1'b0) begin
      errors++;
      $display("FAIL cfg_right: gain %0d req %b sel %b, required 64 1 0", rightHandGain, sensorReq, sensorSel);
    end
    tick(1);
    cfgGain     = 8'd20;
    push_ev(1, 16'd20, cyc + 1);
    sensorValid = 1'b1;
    sensorData  = 16'd777;
    push_ev(0, 16'd777, cyc + 1);
    tick(1);
    cfgWrite    = 1'b0;
    sensorValid = 1'b0;
    checks++;
    if (leftHandGain !== 8'd20 || rightHandGain !== 8'd64 || leftHandDistance !== 16'd777) begin
      errors++;
      $display("FAIL cfg_back_to_back: gains %0d/%0d dist %0d, required 20/64 777", leftHandGain, rightHandGain, leftHandDistance);
    end
    serve(1'b1, 1, 16'd321, rc);
  endtask

  task automatic test_idle_ignore;
    sensorValid = 1'b1;
    sensorData  = 16'h5555;
    tick(2);
    sensorValid = 1'b0;
    checks++;
    if (sensorReq !== 1'b0 || leftHandDistance !== 16'd777 || rightHandDistance !== 16'd321) begin
      errors++;
      $display("FAIL idle_valid: req %b dist %0d/%0d, required 0 777/321", sensorReq, leftHandDistance, rightHandDistance);
    end
  endtask

  task automatic test_reset_mid_req;
    int rc;
    serve(1'b0, 1, 16'd111, rc);
    wait_req(rc);
    tick(1);
    reset       = 1'b1;
    sensorValid = 1'b1;
    sensorData  = 16'd4321;
    tick(1);
    sensorValid = 1'b0;
    checks++;
    if (sensorReq !== 1'b0 || rightHandDistance !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_req: req %b dist %0d, required 0 0", sensorReq, rightHandDistance);
    end
    test_reset();
  endtask

  task automatic test_free_run;
    int rcs [4];
    int rc;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 2, 16'(1000 + i), rc);
      rcs[i] = rc;
      if (i < 3) serve(1'b1, 2, 16'(2000 + i), rc);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rcs[i+1] - rcs[i] != POLL + 6) begin
        errors++;
        $display("FAIL round_period_%0d: %0d cycles, required %0d", i, rcs[i+1] - rcs[i], POLL + 6);
      end
    end
    checks++;
    if (leftFault !== 1'b0 || rightFault !== 1'b0) begin
      errors++;
      $display("FAIL free_run_faults: %b%b, required 00", leftFault, rightFault);
    end
  endtask

  task automatic test_drain;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL %s_missing: %0d expected strobes never seen, required 0", kind_name(k), exp_q[k].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_valid();
    test_right_timeout();
    test_cfg_during_req();
    test_idle_ignore();
    test_reset_mid_req();
    test_free_run();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
